// File: rtl/alu_seq_pkg.sv
// Shared opcode encodings and FSM state type for the sequential ALU.
package alu_pkg;

    // Encodings 0-3 are unchanged from the earlier 2-bit ALU.
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_INC = 3'd3;
    localparam logic [2:0] OP_OR  = 3'd4;
    localparam logic [2:0] OP_XOR = 3'd5;
    localparam logic [2:0] OP_SHL = 3'd6;
    localparam logic [2:0] OP_MUL = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_seq_if.sv
// Operand/result channel of the sequential ALU; master = producer/consumer side, slave = ALU.
interface alu_seq_if #(
    parameter int DATA_WIDTH = 8
);
    // Both channels: a transfer happens on a rising clk edge where valid && ready.
    // A source holds valid and its payload until that edge; ready may depend on state.
    logic                  in_valid;
    logic                  in_ready;
    logic [2:0]            alu_op;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_alu;
    logic                  flag_z;
    logic                  flag_n;
    logic                  flag_c;
    logic                  flag_v;

    modport master (
        output in_valid, alu_op, a, b, out_ready,
        input  in_ready, out_valid, out_alu, flag_z, flag_n, flag_c, flag_v
    );

    modport slave (
        input  in_valid, alu_op, a, b, out_ready,
        output in_ready, out_valid, out_alu, flag_z, flag_n, flag_c, flag_v
    );
endinterface

// File: rtl/alu_mul_iter.sv
// Iterative shift-add unsigned multiplier: one partial product per cycle after start.
module alu_mul_iter #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_W      = $clog2(DATA_WIDTH) + 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [DATA_WIDTH-1:0]   a,
    input  logic [DATA_WIDTH-1:0]   b,
    output logic                    done,
    output logic [2*DATA_WIDTH-1:0] product
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_WIDTH - 1);

    logic                    running;
    logic [CNT_W-1:0]        cnt;
    logic [2*DATA_WIDTH-1:0] mcand;
    logic [DATA_WIDTH-1:0]   mplr;
    logic [2*DATA_WIDTH-1:0] acc;
    logic [2*DATA_WIDTH-1:0] acc_next;

    // product is the accumulator after the current step, so it is final in the done cycle.
    assign acc_next = acc + (mplr[0] ? mcand : '0);
    assign done     = running && (cnt == LAST);
    assign product  = acc_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            running <= 1'b0;
            cnt     <= '0;
            mcand   <= '0;
            mplr    <= '0;
            acc     <= '0;
        end else if (start) begin
            running <= 1'b1;
            cnt     <= '0;
            mcand   <= {{DATA_WIDTH{1'b0}}, a};
            mplr    <= b;
            acc     <= '0;
        end else if (running) begin
            acc   <= acc_next;
            mcand <= mcand << 1;
            mplr  <= mplr >> 1;
            cnt   <= cnt + 1'b1;
            if (done) begin
                running <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Registered 8-op ALU with status flags and valid/ready handshakes; MUL is multi-cycle.
module alu_seq
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int SHAMT_W    = $clog2(DATA_WIDTH),
    parameter int CNT_W      = $clog2(DATA_WIDTH) + 1
) (
    input  logic      clk,
    input  logic      rst_n,
    alu_seq_if.slave  bus,
    output state_t    dbg_state
);

    localparam int W = DATA_WIDTH;

    state_t state, state_nxt;
    logic   in_ready;
    logic   accept;
    logic   is_mul;
    logic   mul_start;
    logic   mul_done;
    logic [2*W-1:0] mul_prod;

    logic [W:0]   ext;
    logic [W-1:0] op_res;
    logic         op_c;
    logic         op_v;
    logic [W-1:0] ld_res;
    logic         ld_c;
    logic         ld_v;
    logic         load_op;
    logic         load_mul;

    logic [W-1:0] out_alu_q;
    logic         z_q, n_q, c_q, v_q;

    assign in_ready  = (state == ST_IDLE) || ((state == ST_DONE) && bus.out_ready);
    assign accept    = bus.in_valid && in_ready;
    assign is_mul    = (bus.alu_op == OP_MUL);
    assign mul_start = accept && is_mul;
    assign load_op   = accept && !is_mul;
    assign load_mul  = (state == ST_BUSY) && mul_done;

    alu_mul_iter #(
        .DATA_WIDTH (W),
        .CNT_W      (CNT_W)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (bus.a),
        .b       (bus.b),
        .done    (mul_done),
        .product (mul_prod)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = is_mul ? ST_BUSY : ST_DONE;
            ST_BUSY: if (mul_done) state_nxt = ST_DONE;
            ST_DONE: begin
                if (bus.out_ready) begin
                    if (accept) state_nxt = is_mul ? ST_BUSY : ST_DONE;
                    else        state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Arithmetic runs one bit wider so bit W is the carry/borrow/shift-out.
    always_comb begin
        ext    = '0;
        op_res = '0;
        op_c   = 1'b0;
        op_v   = 1'b0;
        case (bus.alu_op)
            OP_ADD: begin
                ext    = {1'b0, bus.a} + {1'b0, bus.b};
                op_res = ext[W-1:0];
                op_c   = ext[W];
                op_v   = (bus.a[W-1] == bus.b[W-1]) && (op_res[W-1] != bus.a[W-1]);
            end
            OP_SUB: begin
                ext    = {1'b0, bus.a} - {1'b0, bus.b};
                op_res = ext[W-1:0];
                op_c   = ext[W];
                op_v   = (bus.a[W-1] != bus.b[W-1]) && (op_res[W-1] != bus.a[W-1]);
            end
            OP_INC: begin
                ext    = {1'b0, bus.a} + (W+1)'(1);
                op_res = ext[W-1:0];
                op_c   = ext[W];
                op_v   = !bus.a[W-1] && op_res[W-1];
            end
            OP_AND: op_res = bus.a & bus.b;
            OP_OR:  op_res = bus.a | bus.b;
            OP_XOR: op_res = bus.a ^ bus.b;
            OP_SHL: begin
                ext    = {1'b0, bus.a} << bus.b[SHAMT_W-1:0];
                op_res = ext[W-1:0];
                op_c   = ext[W];
            end
            default: begin
                op_res = '0;
            end
        endcase
    end

    always_comb begin
        ld_res = op_res;
        ld_c   = op_c;
        ld_v   = op_v;
        if (load_mul) begin
            ld_res = mul_prod[W-1:0];
            ld_c   = |mul_prod[2*W-1:W];
            ld_v   = 1'b0;
        end
    end

    // Result and flags are written only when entering DONE, so they hold under backpressure.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_alu_q <= '0;
            z_q       <= 1'b0;
            n_q       <= 1'b0;
            c_q       <= 1'b0;
            v_q       <= 1'b0;
        end else if (load_op || load_mul) begin
            out_alu_q <= ld_res;
            z_q       <= (ld_res == '0);
            n_q       <= ld_res[W-1];
            c_q       <= ld_c;
            v_q       <= ld_v;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state == ST_DONE);
    assign bus.out_alu   = out_alu_q;
    assign bus.flag_z    = z_q;
    assign bus.flag_n    = n_q;
    assign bus.flag_c    = c_q;
    assign bus.flag_v    = v_q;
    assign dbg_state     = state;

endmodule
